// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-master I2C controller issuing one-byte read or write transactions.
// SCL is derived from clk; every bit slot is four phases of CLK_DIV clocks each.
module i2c_master_ctrl #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       scl,
    inout  wire        sda
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_AACK,
        S_WDATA,
        S_WACK,
        S_RDATA,
        S_MNACK,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       phase_q, phase_d;
    logic [2:0]       bit_q, bit_d;
    logic             rw_q, rw_d;
    logic [6:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic             nack_q, nack_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             scl_q, scl_d;
    logic             sda_oe_q, sda_oe_d;

    logic sda_in;
    logic tick;
    logic sample_tick;
    logic slot_end;

    // Open-drain pad: only ever pull low, otherwise release to the pull-up.
    assign sda    = sda_oe_q ? 1'b0 : 1'bz;
    assign sda_in = sda;

    assign tick        = (div_q == DIV_LAST);
    assign sample_tick = tick && (phase_q == 2'd2);
    assign slot_end    = tick && (phase_q == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            phase_q   <= 2'd0;
            bit_q     <= 3'd0;
            rw_q      <= 1'b0;
            addr_q    <= 7'd0;
            wdata_q   <= 8'd0;
            tx_q      <= 8'd0;
            rx_q      <= 8'd0;
            nack_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rdata_q   <= 8'd0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            nack_q    <= nack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            rdata_q   <= rdata_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    // Transaction sequencer: divider, phase/slot stepping, bus sampling and state transitions.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        nack_d    = nack_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        rdata_d   = rdata_q;

        if (state_q == S_IDLE) begin
            div_d   = '0;
            phase_d = 2'd0;
            bit_d   = 3'd0;
            if (req) begin
                rw_d      = rw;
                addr_d    = addr;
                wdata_d   = wdata;
                rx_d      = 8'd0;
                nack_d    = 1'b0;
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
                state_d   = S_START;
            end
        end else begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                phase_d = phase_q + 2'd1;
            end

            if (sample_tick) begin
                case (state_q)
                    S_AACK, S_WACK: nack_d = sda_in;
                    S_RDATA:        rx_d   = {rx_q[6:0], sda_in};
                    default:        ;
                endcase
            end

            if (slot_end) begin
                case (state_q)
                    S_START: begin
                        state_d = S_ADDR;
                        bit_d   = 3'd0;
                        tx_d    = {addr_q, rw_q};
                    end
                    S_ADDR, S_WDATA: begin
                        if (bit_q == 3'd7) begin
                            bit_d   = 3'd0;
                            state_d = (state_q == S_ADDR) ? S_AACK : S_WACK;
                        end else begin
                            bit_d = bit_q + 3'd1;
                            tx_d  = {tx_q[6:0], 1'b0};
                        end
                    end
                    S_AACK: begin
                        if (nack_q) begin
                            ack_err_d = 1'b1;
                            state_d   = S_STOP;
                        end else if (rw_q) begin
                            state_d = S_RDATA;
                        end else begin
                            state_d = S_WDATA;
                            tx_d    = wdata_q;
                        end
                    end
                    S_WACK: begin
                        ack_err_d = nack_q;
                        state_d   = S_STOP;
                    end
                    S_RDATA: begin
                        if (bit_q == 3'd7) begin
                            bit_d   = 3'd0;
                            rdata_d = rx_q;
                            state_d = S_MNACK;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                    S_MNACK: state_d = S_STOP;
                    S_STOP: begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Bus pins are decoded from the next state so they register in step with it.
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            S_START: begin
                scl_d    = (phase_d != 2'd3);
                sda_oe_d = (phase_d != 2'd0);
            end
            S_STOP: begin
                scl_d    = (phase_d != 2'd0);
                sda_oe_d = ~phase_d[1];
            end
            S_ADDR, S_WDATA: begin
                scl_d    = phase_d[1];
                sda_oe_d = ~tx_d[7];
            end
            S_AACK, S_WACK, S_RDATA, S_MNACK: begin
                scl_d = phase_d[1];
            end
            default: ;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;
    assign scl     = scl_q;

endmodule
